// File: rtl/ws2812b_driver.sv
// WS2812B single-wire serialiser: sends NUM_LEDS x 24 bits (G,R,B, MSB first)
// per refresh, then holds the line low for the latch gap and pulses done.
// A refresh arriving mid-frame is remembered and starts the next frame
// right after the current latch gap, without dropping busy.
module ws2812b_driver #(
   parameter int NUM_LEDS     = 12,
   parameter int BIT_CYCLES   = 50,
   parameter int T0H_CYCLES   = 16,
   parameter int T1H_CYCLES   = 32,
   parameter int RESET_CYCLES = 2400
) (
   input  logic                clk,
   input  logic                res,
   input  logic                refresh,
   input  logic [NUM_LEDS-1:0] led_mask,
   input  logic [7:0]          intensity,
   output logic                led_out,
   output logic                busy,
   output logic                done
);

   localparam int TOTAL_BITS = NUM_LEDS * 24;
   localparam int BW         = $clog2(TOTAL_BITS);
   localparam int MAXC       = (BIT_CYCLES > RESET_CYCLES) ? BIT_CYCLES : RESET_CYCLES;
   localparam int CW         = $clog2(MAXC);

   typedef enum logic [1:0] {S_IDLE, S_HIGH, S_LOW, S_LATCH} state_t;

   state_t              r_state;
   logic [CW-1:0]       r_cnt;
   logic [BW-1:0]       r_bit_cnt;
   logic [4:0]          r_sub;
   logic                r_pending;
   logic                r_led_out;
   logic                r_busy;
   logic                r_done;
   logic [NUM_LEDS-1:0] r_mask;
   logic [7:0]          r_int;

   logic [CW-1:0]       w_cnt_nxt;
   logic                w_bit;
   logic                w_high_end;
   logic                w_bit_end;
   logic                w_last_bit;
   logic                w_led_end;
   logic                w_latch_end;
   logic                w_start;

   // Current bit: r_mask[0] is the LED being sent; all three bytes carry the same level.
   assign w_cnt_nxt   = r_cnt + CW'(1);
   assign w_bit       = r_mask[0] & r_int[3'd7 - r_sub[2:0]];
   assign w_high_end  = (r_state == S_HIGH) &&
                        (w_cnt_nxt == (w_bit ? CW'(T1H_CYCLES) : CW'(T0H_CYCLES)));
   assign w_bit_end   = (r_state == S_LOW) && (r_cnt == CW'(BIT_CYCLES - 1));
   assign w_last_bit  = (r_bit_cnt == BW'(TOTAL_BITS - 1));
   assign w_led_end   = (r_sub == 5'd23);
   assign w_latch_end = (r_state == S_LATCH) && (r_cnt == CW'(RESET_CYCLES - 1));
   // A frame starts from idle, or back-to-back when a request is waiting at the end of the gap.
   assign w_start     = ((r_state == S_IDLE) && refresh) ||
                        (w_latch_end && (r_pending || refresh));

   assign led_out = r_led_out;
   assign busy    = r_busy;
   assign done    = r_done;

   // Frame snapshot and per-LED mask shift; data only, so no reset.
   always_ff @(posedge clk) begin
      if (w_start) begin
         r_mask <= led_mask;
         r_int  <= intensity;
      end else if (w_bit_end && w_led_end) begin
         r_mask <= r_mask >> 1;
      end
   end

   // Frame FSM: bit high/low phases, latch gap, pending request and registered outputs.
   always_ff @(posedge clk or posedge res) begin
      if (res) begin
         r_state   <= S_IDLE;
         r_cnt     <= '0;
         r_bit_cnt <= '0;
         r_sub     <= '0;
         r_pending <= 1'b0;
         r_led_out <= 1'b0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (w_start) begin
            r_state   <= S_HIGH;
            r_cnt     <= '0;
            r_bit_cnt <= '0;
            r_sub     <= '0;
            r_pending <= 1'b0;
            r_led_out <= 1'b1;
            r_busy    <= 1'b1;
         end else begin
            if (refresh && (r_state != S_IDLE))
               r_pending <= 1'b1;
            case (r_state)
               S_IDLE: begin
                  r_cnt <= '0;
               end
               S_HIGH: begin
                  r_cnt <= w_cnt_nxt;
                  if (w_high_end) begin
                     r_state   <= S_LOW;
                     r_led_out <= 1'b0;
                  end
               end
               S_LOW: begin
                  if (w_bit_end) begin
                     r_cnt <= '0;
                     if (w_last_bit) begin
                        r_state <= S_LATCH;
                     end else begin
                        r_state   <= S_HIGH;
                        r_led_out <= 1'b1;
                        r_bit_cnt <= r_bit_cnt + BW'(1);
                        r_sub     <= w_led_end ? 5'd0 : r_sub + 5'd1;
                     end
                  end else begin
                     r_cnt <= w_cnt_nxt;
                  end
               end
               S_LATCH: begin
                  if (w_latch_end) begin
                     r_state <= S_IDLE;
                     r_busy  <= 1'b0;
                     r_cnt   <= '0;
                  end else begin
                     r_cnt <= w_cnt_nxt;
                     if (r_cnt == CW'(RESET_CYCLES - 2))
                        r_done <= 1'b1;
                  end
               end
               default: r_state <= S_IDLE;
            endcase
         end
      end
   end

endmodule
